// File: rtl/led_driver.sv
// LED driver: OFF / ON / BLINK / PULSE command-driven LED controller.
// Commands use a valid/ready handshake. A command transfers on a rising
// edge where cmd_valid=1 and cmd_ready=1; cmd_ready drops during PULSE
// sequences, and commands presented then are dropped, not queued.
// Optional build macro LED_DRIVER_PWM_EN adds a 4-bit duty input that
// dims the lit phases with a free-running 4-bit PWM counter.
module led_driver #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_count,
`ifdef LED_DRIVER_PWM_EN
  input  logic [3:0] duty,
`endif
  output logic       cmd_ready,
  output logic       led,
  output logic [1:0] mode,
  output logic       done
);

  localparam int PW = $clog2(HALF_PERIOD + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK_HI,
    S_BLINK_LO,
    S_PULSE_HI,
    S_PULSE_LO
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase_cnt, phase_nxt;
  logic [3:0]      flash_cnt, flash_nxt;
  logic            done_nxt;
  logic            lit;
  logic            phase_end;

  assign phase_end = (phase_cnt == PHASE_LAST);

  // State, counters and the registered done pulse; reset wins over commands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_OFF;
      phase_cnt <= '0;
      flash_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_nxt;
      flash_cnt <= flash_nxt;
      done      <= done_nxt;
    end
  end

  // Moore outputs plus next-state: a command when accepted, else phase timing.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    flash_nxt = flash_cnt;
    done_nxt  = 1'b0;
    lit       = 1'b0;
    mode      = MODE_OFF;
    cmd_ready = 1'b1;

    case (state)
      S_OFF:      begin lit = 1'b0; mode = MODE_OFF;   cmd_ready = 1'b1; end
      S_ON:       begin lit = 1'b1; mode = MODE_ON;    cmd_ready = 1'b1; end
      S_BLINK_HI: begin lit = 1'b1; mode = MODE_BLINK; cmd_ready = 1'b1; end
      S_BLINK_LO: begin lit = 1'b0; mode = MODE_BLINK; cmd_ready = 1'b1; end
      S_PULSE_HI: begin lit = 1'b1; mode = MODE_PULSE; cmd_ready = 1'b0; end
      S_PULSE_LO: begin lit = 1'b0; mode = MODE_PULSE; cmd_ready = 1'b0; end
      default:    begin lit = 1'b0; mode = MODE_OFF;   cmd_ready = 1'b1; end
    endcase

    if (cmd_valid && cmd_ready) begin
      // Every accepted command restarts from its first phase, counters cleared.
      phase_nxt = '0;
      flash_nxt = '0;
      case (cmd_mode)
        MODE_OFF:   state_nxt = S_OFF;
        MODE_ON:    state_nxt = S_ON;
        MODE_BLINK: state_nxt = S_BLINK_HI;
        default: begin
          if (cmd_count == 4'd0) begin
            state_nxt = S_OFF;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_PULSE_HI;
            flash_nxt = cmd_count;
          end
        end
      endcase
    end else begin
      case (state)
        S_BLINK_HI, S_BLINK_LO: begin
          if (phase_end) begin
            phase_nxt = '0;
            state_nxt = (state == S_BLINK_HI) ? S_BLINK_LO : S_BLINK_HI;
          end else begin
            phase_nxt = phase_cnt + PHASE_ONE;
          end
        end
        S_PULSE_HI: begin
          if (phase_end) begin
            phase_nxt = '0;
            flash_nxt = flash_cnt - 4'd1;
            if (flash_cnt == 4'd1) begin
              state_nxt = S_OFF;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_PULSE_LO;
            end
          end else begin
            phase_nxt = phase_cnt + PHASE_ONE;
          end
        end
        S_PULSE_LO: begin
          if (phase_end) begin
            phase_nxt = '0;
            state_nxt = S_PULSE_HI;
          end else begin
            phase_nxt = phase_cnt + PHASE_ONE;
          end
        end
        default: begin
          phase_nxt = '0;
        end
      endcase
    end
  end

`ifdef LED_DRIVER_PWM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM counter; dims lit phases only, never affects FSM timing.
  always_ff @(posedge clk) begin
    if (!reset) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign led = lit && (pwm_cnt < duty);
`else
  assign led = lit;
`endif

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver (HALF_PERIOD=4). Inputs change and outputs
// are sampled on the falling edge; accept edge t is the rising edge after
// inputs are set, so the first check after one tick sees cycle t+1.
module tb_led_driver;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_count;
  logic       cmd_ready;
  logic       led;
  logic [1:0] mode;
  logic       done;
`ifdef LED_DRIVER_PWM_EN
  logic [3:0] duty;
`endif

  int total = 0;
  int bad   = 0;

  led_driver #(.HALF_PERIOD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
`ifdef LED_DRIVER_PWM_EN
    .duty      (duty),
`endif
    .cmd_ready (cmd_ready),
    .led       (led),
    .mode      (mode),
    .done      (done)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for one accept edge, then withdraw it.
  task automatic send(input logic [1:0] m, input logic [3:0] n);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_count = n;
    tick();
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_count = 4'd0;
  endtask

  task automatic check_all(input string tag, input logic l, input logic [1:0] m,
                           input logic r, input logic d);
    check({tag, ".led"},   {3'b0, led},       {3'b0, l});
    check({tag, ".mode"},  {2'b0, mode},      {2'b0, m});
    check({tag, ".ready"}, {3'b0, cmd_ready}, {3'b0, r});
    check({tag, ".done"},  {3'b0, done},      {3'b0, d});
  endtask

  initial begin
    logic exp_led;
    int   k;
    int   hi_cnt;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    cmd_count = 4'd0;
`ifdef LED_DRIVER_PWM_EN
    duty      = 4'd15;
`endif
    tick();
    tick();
    check_all("reset", 1'b0, 2'b00, 1'b1, 1'b0);
    reset = 1'b1;
    tick();

`ifndef LED_DRIVER_PWM_EN
    // ON then OFF.
    send(2'b01, 4'd0);
    check_all("on_t1", 1'b1, 2'b01, 1'b1, 1'b0);
    tick();
    check_all("on_t2", 1'b1, 2'b01, 1'b1, 1'b0);
    send(2'b00, 4'd0);
    check_all("off_t1", 1'b0, 2'b00, 1'b1, 1'b0);

    // BLINK: 4 high / 4 low, three full periods.
    send(2'b10, 4'd0);
    for (int i = 1; i <= 24; i++) begin
      exp_led = (((i - 1) / 4) % 2) == 0;
      check_all($sformatf("blink_t%0d", i), exp_led, 2'b10, 1'b1, 1'b0);
      if (i < 24) tick();
    end

    // BLINK re-issued mid low phase restarts from the lit phase.
    send(2'b00, 4'd0);
    send(2'b10, 4'd0);
    for (int i = 1; i < 6; i++) tick();
    check_all("blink_pre_restart", 1'b0, 2'b10, 1'b1, 1'b0);
    send(2'b10, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      exp_led = (i <= 4);
      check_all($sformatf("blink_restart_t%0d", i), exp_led, 2'b10, 1'b1, 1'b0);
      tick();
    end
    send(2'b00, 4'd0);
    check_all("off_after_blink", 1'b0, 2'b00, 1'b1, 1'b0);

    // PULSE N=2, with an ON request presented in t+6 that must be ignored.
    send(2'b11, 4'd2);
    for (int i = 1; i <= 14; i++) begin
      if (i <= 12) begin
        exp_led = (i <= 4) || (i >= 9);
        check_all($sformatf("pulse2_t%0d", i), exp_led, 2'b11, 1'b0, 1'b0);
      end else if (i == 13) begin
        check_all("pulse2_t13", 1'b0, 2'b00, 1'b1, 1'b1);
      end else begin
        check_all("pulse2_t14", 1'b0, 2'b00, 1'b1, 1'b0);
      end
      cmd_valid = (i == 6);
      cmd_mode  = (i == 6) ? 2'b01 : 2'b00;
      tick();
    end
    cmd_valid = 1'b0;

    // PULSE N=0 completes immediately.
    send(2'b11, 4'd0);
    check_all("pulse0_t1", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();
    check_all("pulse0_t2", 1'b0, 2'b00, 1'b1, 1'b0);

    // PULSE N=15: done only after 15 lit phases (117 cycles).
    send(2'b11, 4'd15);
    k = 1;
    while (k < 117 && done !== 1'b1) begin
      tick();
      k++;
    end
    check("pulse15_done_cycle", 4'(k), 4'(117));
    check_all("pulse15_end", 1'b0, 2'b00, 1'b1, 1'b1);
    tick();

    // Reset at t+6 of a BLINK together with an ON command.
    send(2'b10, 4'd0);
    for (int i = 1; i < 5; i++) tick();
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    tick();
    check_all("blink_reset", 1'b0, 2'b00, 1'b1, 1'b0);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'b00;
    tick();
    check_all("blink_reset_after", 1'b0, 2'b00, 1'b1, 1'b0);

    // Reset mid PULSE aborts without a done pulse.
    send(2'b11, 4'd1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      check_all($sformatf("pulse_abort_t%0d", i), 1'b0, 2'b00, 1'b1, 1'b0);
      tick();
    end

    // PULSE N=1 boundary.
    send(2'b11, 4'd1);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) check_all($sformatf("pulse1_t%0d", i), 1'b1, 2'b11, 1'b0, 1'b0);
      else        check_all("pulse1_t5", 1'b0, 2'b00, 1'b1, 1'b1);
      tick();
    end
`else
    // PWM dimming in ON mode.
    duty = 4'd4;
    send(2'b01, 4'd0);
    check("pwm_on_mode", {2'b0, mode}, 4'h1);
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led === 1'b1) hi_cnt++;
      tick();
    end
    check("pwm_duty4_count", 4'(hi_cnt), 4'd4);
    duty   = 4'd0;
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led !== 1'b0) hi_cnt++;
      tick();
    end
    check("pwm_duty0_count", 4'(hi_cnt), 4'd0);
    check("pwm_ready", {3'b0, cmd_ready}, 4'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
